// File: rtl/vr_vc_if.sv
// vr_vc_if: upstream valid/ready plus downstream valid/credit link
// slave = bridge side, master = producer/consumer side
interface vr_vc_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_credit_i;
  logic                  credit_err_o;

  modport slave (
    input  s_data_i,
    input  s_valid_i,
    input  m_credit_i,
    output s_ready_o,
    output m_data_o,
    output m_valid_o,
    output credit_err_o
  );

  modport master (
    output s_data_i,
    output s_valid_i,
    output m_credit_i,
    input  s_ready_o,
    input  m_data_o,
    input  m_valid_o,
    input  credit_err_o
  );
endinterface

// File: rtl/vr_vc_converter.sv
// vr_vc_converter: valid/ready to valid/credit bridge
// 2-entry skid FIFO drained against a local downstream credit count
module vr_vc_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input logic      clk,
  input logic      rst_n,
  vr_vc_if.slave   bus
);
  localparam int CW = $clog2(CREDIT_NUM + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_NUM);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic [CW-1:0]         cnt;
  logic                  ready_en;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  err_q;

  logic push;
  logic send;
  logic cr_dec;
  logic cr_inc;
  logic cr_ovf;

  assign bus.s_ready_o    = ready_en && (occ != 2'd2);
  assign bus.m_data_o     = m_data_q;
  assign bus.m_valid_o    = m_valid_q;
  assign bus.credit_err_o = err_q;

  assign push = bus.s_valid_i && bus.s_ready_o;
  assign send = (occ != 2'd0) && (cnt != '0);

  // send and return on the same edge cancel out
  assign cr_dec = send && !bus.m_credit_i;
  assign cr_inc = !send && bus.m_credit_i && (cnt != CMAX);
  assign cr_ovf = !send && bus.m_credit_i && (cnt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      cnt       <= CMAX;
      ready_en  <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      m_valid_q <= send;
      occ       <= occ + {1'b0, push} - {1'b0, send};
      if (push) begin
        mem[wr_ptr] <= bus.s_data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (send) begin
        m_data_q <= mem[rd_ptr];
        rd_ptr   <= ~rd_ptr;
      end
      unique case (1'b1)
        cr_dec:  cnt   <= cnt - CW'(1);
        cr_inc:  cnt   <= cnt + CW'(1);
        cr_ovf:  err_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vr_vc_converter.sv
// tb_vr_vc_converter: scoreboard bench with directed and random traffic
// reference tracks accepted flits and flits-in-flight as plain counts
module tb_vr_vc_converter;
  localparam int CN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vr_vc_if #(.DATA_WIDTH(8)) bus();

  vr_vc_converter #(
    .DATA_WIDTH(8),
    .CREDIT_NUM(CN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sends  = 0;
  int outst  = 0;
  bit exp_send  = 1'b0;
  bit exp_err   = 1'b0;
  bit rdy_model = 1'b0;
  logic [7:0] sbq[$];
  logic [7:0] sent_log[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nth_last(input int k);
    if (sent_log.size() > k)
      return sent_log[sent_log.size() - 1 - k];
    return 8'hxx;
  endfunction

  always @(negedge rst_n) begin
    sbq.delete();
    outst     = 0;
    exp_send  = 1'b0;
    exp_err   = 1'b0;
    rdy_model = 1'b0;
  end

  // late in each cycle: predict the coming edge, record handshakes
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_send = 1'b0;
    end else begin
      chk("s_ready", bus.s_ready_o, rdy_model && sbq.size() < 2);
      exp_send = (sbq.size() > 0) && (outst < CN);
      if (exp_send) outst++;
      if (bus.m_credit_i) begin
        if (outst > 0) outst--;
        else exp_err = 1'b1;
      end
      if (bus.s_valid_i && bus.s_ready_o)
        sbq.push_back(bus.s_data_i);
    end
  end

  // just after each edge: compare what the link shows
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      rdy_model = 1'b1;
      chk("m_valid", bus.m_valid_o, exp_send);
      chk("credit_err", bus.credit_err_o, exp_err);
      if (bus.m_valid_o) begin
        sends++;
        sent_log.push_back(bus.m_data_o);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scb_empty: got %0h expected none",
                   bus.m_data_o);
        end else begin
          chk("m_data", bus.m_data_o, sbq.pop_front());
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    bus.s_valid_i  = 1'b0;
    bus.m_credit_i = 1'b0;
  endtask

  task automatic credit();
    @(negedge clk);
    bus.s_valid_i  = 1'b0;
    bus.m_credit_i = 1'b1;
    @(negedge clk);
    bus.m_credit_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    bus.s_valid_i  = 1'b1;
    bus.s_data_i   = d;
    bus.m_credit_i = 1'b0;
    while (!bus.s_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 1, 0);
    @(posedge clk);
  endtask

  int s0;

  initial begin
    bus.s_valid_i  = 1'b0;
    bus.s_data_i   = 8'h00;
    bus.m_credit_i = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid_o, 0);
    chk("rst_m_data", bus.m_data_o, 0);
    chk("rst_s_ready", bus.s_ready_o, 0);
    chk("rst_err", bus.credit_err_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", bus.s_ready_o, 0);
    @(negedge clk);
    chk("ready_post_edge", bus.s_ready_o, 1);

    // first flit
    push(8'hAA);
    repeat (3) idle();
    chk("first_count", sends, 1);
    chk("first_data", nth_last(0), 8'hAA);

    // credit exhaustion
    credit();
    s0 = sends;
    push(8'hBB);
    push(8'hCC);
    push(8'hDD);
    repeat (3) idle();
    chk("exh_count", sends - s0, 2);
    chk("exh_last", nth_last(0), 8'hCC);
    chk("exh_ready", bus.s_ready_o, 1);
    push(8'hEE);
    idle();
    chk("exh_full", bus.s_ready_o, 0);
    credit();
    idle();
    chk("rel_count", sends - s0, 3);
    chk("rel_dd", nth_last(0), 8'hDD);
    credit();
    idle();
    chk("rel_ee", nth_last(0), 8'hEE);

    // full FIFO ordering, cnt already 0
    s0 = sends;
    push(8'h80);
    push(8'h81);
    @(negedge clk);
    bus.s_data_i = 8'h82;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", bus.s_ready_o, 0);
    end
    chk("full_nosend", sends - s0, 0);
    bus.m_credit_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.m_credit_i = 1'b0;
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    chk("ord_count", sends - s0, 2);
    chk("ord_80", nth_last(1), 8'h80);
    chk("ord_81", nth_last(0), 8'h81);
    credit();
    idle();
    chk("ord_82", nth_last(0), 8'h82);

    // invalid data ignored
    credit();
    credit();
    s0 = sends;
    repeat (5) begin
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = 8'h50;
    end
    idle();
    chk("inv_nosend", sends - s0, 0);
    chk("inv_hold", bus.m_data_o, 8'h82);

    // credit overflow
    credit();
    chk("ovf_err", bus.credit_err_o, 1);
    s0 = sends;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    repeat (3) idle();
    chk("ovf_cnt_kept", sends - s0, 2);
    chk("ovf_sticky", bus.credit_err_o, 1);

    // reset mid-stream with 2 buffered, no credit
    push(8'h34);
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", bus.m_valid_o, 0);
    chk("mid_s_ready", bus.s_ready_o, 0);
    chk("mid_err", bus.credit_err_o, 0);
    chk("mid_m_data", bus.m_data_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = sends;
    idle();
    push(8'h11);
    push(8'h12);
    repeat (4) idle();
    chk("post_count", sends - s0, 2);
    chk("post_11", nth_last(1), 8'h11);
    chk("post_12", nth_last(0), 8'h12);
    credit();
    credit();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.s_valid_i  = ($urandom % 2) == 0;
      bus.s_data_i   = 8'($urandom);
      bus.m_credit_i = (outst > 0 && ($urandom % 3) == 0) ||
                       (($urandom % 700) == 0);
    end

    // drain
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus.s_valid_i  = 1'b0;
      bus.m_credit_i = (outst > 0);
      if (sbq.size() == 0 && outst == 0 && !bus.m_credit_i) break;
    end
    idle();
    chk("drain_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
